// File: rtl/capture_pkg.sv
// Shared types for the capture readout path: FSM states, channel ids, default sizes.
package capture_pkg;

    localparam int CAP_FIFO_SIZE  = 1024;
    localparam int CAP_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_t;

    typedef struct packed {
        chan_t chan;
        logic  last;
    } rd_meta_t;

    // Channel to read next: the preferred one when both still have words, else whichever has any.
    function automatic chan_t pick_chan(input logic have0, input logic have1, input chan_t pref);
        if (have0 && have1) begin
            return pref;
        end
        return have0 ? CH0 : CH1;
    endfunction

endpackage

// File: rtl/capture_readout_arb_if.sv
// Readout sample stream toward firmware: payload plus valid/ready handshake.
interface capture_readout_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_chan;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_chan,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_chan,
        input  m_last,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/capture_readout_arb_skid_buf.sv
// 2-entry FIFO of {chan, last, data} feeding the readout stream.
// Latency: push visible on o_vld the next cycle; flush empties it in one cycle.
// Backpressure: head entry held stable while o_vld & ~i_rdy; a push into a full buffer is dropped.
module readout_skid_buf
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = CAP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_push_vld,
    input  rd_meta_t              i_push_meta,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output rd_meta_t              o_meta,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic [1:0]            o_count
);

    rd_meta_t              r_meta [2];
    logic [DATA_WIDTH-1:0] r_dat  [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic w_pop;
    logic w_push;

    assign o_vld   = (r_count != 2'd0);
    assign o_meta  = r_meta[r_rptr];
    assign o_dat   = r_dat[r_rptr];
    assign o_count = r_count;

    assign w_pop  = o_vld & i_rdy;
    assign w_push = i_push_vld & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_meta[i] <= '0;
                r_dat[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_meta[r_wptr] <= i_push_meta;
                r_dat[r_wptr]  <= i_push_dat;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/capture_readout_arb.sv
// Drains both channel memories after FINISH onto one valid/ready stream; READOUT_INTERLEAVE_EN alternates ch0/ch1.
// Latency: rd_start at T -> first mem_en at T+1, first m_valid at T+3; 1 word/cycle when m_ready=1.
// Backpressure: reads issue only while buffered + in-flight words stay under 2; rd_abort flushes everything.
module capture_readout_arb
    import capture_pkg::*;
#(
    parameter int FIFO_SIZE       = CAP_FIFO_SIZE,
    parameter int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1,
    parameter int DATA_WIDTH      = CAP_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       finish_op,
    input  logic [FIFO_SIZE_WIDTH-1:0] data_count_ch0,
    input  logic [FIFO_SIZE_WIDTH-1:0] data_count_ch1,
    input  logic                       rd_start,
    input  logic                       rd_abort,
    output logic                       mem_en_ch0,
    output logic                       mem_en_ch1,
    output logic [FIFO_SIZE_WIDTH-2:0] mem_addr_ch0,
    output logic [FIFO_SIZE_WIDTH-2:0] mem_addr_ch1,
    input  logic [DATA_WIDTH-1:0]      mem_data_ch0,
    input  logic [DATA_WIDTH-1:0]      mem_data_ch1,
    capture_readout_arb_if.master      m_if,
    output logic                       readout_busy,
    output logic                       readout_done,
    output logic                       event_rd_start_when_not_ready
);

    localparam int AW = FIFO_SIZE_WIDTH - 1;
    localparam logic [FIFO_SIZE_WIDTH-1:0] LP_MAX = FIFO_SIZE_WIDTH'(FIFO_SIZE);
    localparam logic [FIFO_SIZE_WIDTH-1:0] LP_ONE = FIFO_SIZE_WIDTH'(1);

    rd_state_t                r_state;
    logic [FIFO_SIZE_WIDTH-1:0] r_rem0;
    logic [FIFO_SIZE_WIDTH-1:0] r_rem1;
    logic [AW-1:0]            r_addr0;
    logic [AW-1:0]            r_addr1;
    logic                     r_inflight;
    rd_meta_t                 r_inflight_meta;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_evt;

    logic [FIFO_SIZE_WIDTH-1:0] w_n0;
    logic [FIFO_SIZE_WIDTH-1:0] w_n1;
    logic [FIFO_SIZE_WIDTH-1:0] w_sel_rem;
    logic [FIFO_SIZE_WIDTH-1:0] w_oth_rem;
    logic                     w_have0;
    logic                     w_have1;
    logic                     w_start;
    logic                     w_credit;
    logic                     w_issue;
    logic                     w_last;
    logic                     w_pop;
    logic                     w_drained;
    logic                     w_skid_vld;
    logic [1:0]               w_cnt;
    logic [2:0]               w_occ;
    chan_t                    w_sel;
    chan_t                    w_pref;
    rd_meta_t                 w_head_meta;
    logic [DATA_WIDTH-1:0]    w_head_dat;
    logic [DATA_WIDTH-1:0]    w_ret_dat;

    assign w_n0 = (data_count_ch0 > LP_MAX) ? LP_MAX : data_count_ch0;
    assign w_n1 = (data_count_ch1 > LP_MAX) ? LP_MAX : data_count_ch1;

    assign w_have0 = (r_rem0 != '0);
    assign w_have1 = (r_rem1 != '0);
    assign w_start = (r_state == IDLE) & finish_op & rd_start & ~rd_abort;

    // Credit: words already buffered plus the one in flight, less what leaves this cycle.
    assign w_pop    = w_skid_vld & m_if.m_ready;
    assign w_occ    = {1'b0, w_cnt} + {2'b0, r_inflight};
    assign w_credit = w_occ < (3'd2 + {2'b0, w_pop});

    assign w_sel     = pick_chan(w_have0, w_have1, w_pref);
    assign w_sel_rem = (w_sel == CH0) ? r_rem0 : r_rem1;
    assign w_oth_rem = (w_sel == CH0) ? r_rem1 : r_rem0;
    assign w_issue   = (r_state == READ) & (w_have0 | w_have1) & w_credit & ~rd_abort;
    assign w_last    = (w_sel_rem == LP_ONE) & (w_oth_rem == '0);

    assign mem_en_ch0   = w_issue & (w_sel == CH0);
    assign mem_en_ch1   = w_issue & (w_sel == CH1);
    assign mem_addr_ch0 = r_addr0;
    assign mem_addr_ch1 = r_addr1;

    assign w_ret_dat = (r_inflight_meta.chan == CH1) ? mem_data_ch1 : mem_data_ch0;
    assign w_drained = (w_cnt == 2'd0) | ((w_cnt == 2'd1) & w_pop);

`ifdef READOUT_INTERLEAVE_EN
    chan_t r_pref;

    always_ff @(posedge clk) begin
        if (rst || rd_abort || w_start) begin
            r_pref <= CH0;
        end else if (w_issue) begin
            r_pref <= (w_sel == CH0) ? CH1 : CH0;
        end
    end

    assign w_pref = r_pref;
`else
    assign w_pref = CH0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rem0          <= '0;
            r_rem1          <= '0;
            r_addr0         <= '0;
            r_addr1         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_meta <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_evt           <= 1'b0;
        end else begin
            r_evt      <= rd_start & ~rd_abort & ((r_state != IDLE) | ~finish_op);
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_meta <= '{chan: w_sel, last: w_last};
                // The address stops on the channel's final word so it never wraps.
                if (w_sel == CH0) begin
                    r_rem0 <= r_rem0 - LP_ONE;
                    if (r_rem0 != LP_ONE) r_addr0 <= r_addr0 + AW'(1);
                end else begin
                    r_rem1 <= r_rem1 - LP_ONE;
                    if (r_rem1 != LP_ONE) r_addr1 <= r_addr1 + AW'(1);
                end
            end

            if (rd_abort) begin
                r_state    <= IDLE;
                r_rem0     <= '0;
                r_rem1     <= '0;
                r_addr0    <= '0;
                r_addr1    <= '0;
                r_inflight <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_rem0  <= w_n0;
                            r_rem1  <= w_n1;
                            r_addr0 <= '0;
                            r_addr1 <= '0;
                            if ((w_n0 == '0) && (w_n1 == '0)) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= READ;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (w_issue && w_last) r_state <= DRAIN;
                    end
                    DRAIN: begin
                        if (!r_inflight && w_drained) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (!finish_op) begin
                            r_state <= IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    readout_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (rd_abort),
        .i_push_vld  (r_inflight),
        .i_push_meta (r_inflight_meta),
        .i_push_dat  (w_ret_dat),
        .o_vld       (w_skid_vld),
        .i_rdy       (m_if.m_ready),
        .o_meta      (w_head_meta),
        .o_dat       (w_head_dat),
        .o_count     (w_cnt)
    );

    assign m_if.m_valid = w_skid_vld;
    assign m_if.m_data  = w_head_dat;
    assign m_if.m_chan  = w_head_meta.chan;
    assign m_if.m_last  = w_head_meta.last;

    assign readout_busy                  = r_busy;
    assign readout_done                  = r_done;
    assign event_rd_start_when_not_ready = r_evt;

endmodule

// File: doc/capture_readout_arb.md
# capture_readout_arb

Drains the two per-channel sample memories once a capture reaches FINISH and serialises them onto one valid/ready stream toward firmware. It sits beside `system_ctrl`:
- reads `finish_op` and the per-channel data counts;
- owns the memory read ports (address and enable) of both channel buffers;
- arbitrates between ch0 and ch1, absorbing output backpressure with a 2-entry skid buffer.

## Interface
Parameters:
- FIFO_SIZE, 1024: depth of each channel memory in samples.
- FIFO_SIZE_WIDTH, $clog2(FIFO_SIZE)+1: width of the data counts.
- DATA_WIDTH, 32: sample width.

Ports:
- clk  in  1  single clock; one clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- finish_op  in  1  capture finished; memories hold valid data.
- data_count_ch0 / data_count_ch1  in  FIFO_SIZE_WIDTH  samples captured per channel.
- rd_start  in  1  firmware pulse that begins a readout.
- rd_abort  in  1  firmware pulse that cancels a readout.
- mem_en_ch0 / mem_en_ch1  out  1  memory read enable.
- mem_addr_ch0 / mem_addr_ch1  out  FIFO_SIZE_WIDTH-1  memory read address.
- mem_data_ch0 / mem_data_ch1  in  DATA_WIDTH  read data, valid 1 cycle after the enable.
- m_data  out  DATA_WIDTH  output sample.
- m_chan  out  1  source channel of m_data (0 = ch0, 1 = ch1).
- m_last  out  1  final word of the readout.
- m_valid  out  1  output handshake, valid.
- m_ready  in  1  output handshake, ready.
- readout_busy  out  1  high in READ or DRAIN.
- readout_done  out  1  high in DONE.
- event_rd_start_when_not_ready  out  1  1-cycle pulse when rd_start is ignored.

## Operation
States: IDLE, READ, DRAIN, DONE.

Transitions:
- IDLE→READ: rd_start & finish_op.
  - Latch per-channel remaining count N_x = min(data_count_x, FIFO_SIZE).
  - Clear both read addresses.
  - If N_0 + N_1 == 0, go directly to DONE; no words are emitted.
- READ→DRAIN: the last read has been issued.
- DRAIN→DONE: skid buffer empty and no read in flight.
- DONE→IDLE: finish_op deasserted (firmware restarted the capture).
- Any state→IDLE: rd_abort.
  - Skid buffer flushed.
  - In-flight return data discarded.
  - Remaining counts cleared.

Event and precedence rules:
- rd_start sampled while not IDLE or while finish_op is low: ignored, event pulse the next cycle.
- rd_abort takes priority over rd_start in the same cycle.
- rd_start in the same cycle as rd_abort in IDLE: abort wins, nothing starts.

Read issue:
- At most one channel is read per cycle.
- Issue only if (buffer occupancy + in-flight − pop this cycle) < 2. This credit rule never overflows the buffer and still sustains 1 word/cycle when m_ready=1.
- Addresses run 0..N_x−1 and increment per issued read. An address never wraps; the read that issues address N_x−1 ends that channel.
- A channel with N_x == 0 is skipped entirely.

Output:
- m_last is tagged on the read that issues the final word overall and travels with that word.
- m_data, m_chan and m_last stay stable while m_valid & ~m_ready.

Reset:
- All outputs 0, state IDLE, buffer empty.
- rst mid-readout behaves as abort, without the event pulse.

## Timing
- rd_start in cycle T → READ at T+1, first mem_en at T+1, data captured at T+2, first m_valid at T+3.
- Steady state with m_ready=1: one word per cycle.
- m_ready low: at most 2 words buffered, and mem_en stays low until a credit frees.
- The final pop moves DRAIN→DONE the next cycle. readout_done stays high until finish_op falls.

## Configuration
- READOUT_INTERLEAVE_EN defined: in READ, the channels alternate word by word, starting with ch0, while both have words remaining. Once one channel is exhausted, the other continues back-to-back.
- Not defined: all ch0 words are read, then all ch1 words.

## Structure
- Shared package `capture_pkg` holds:
  - the state encodings IDLE/READ/DRAIN/DONE;
  - the CH0/CH1 channel ids;
  - the default widths.
- Sub-module `readout_skid_buf`: a 2-entry buffer of {chan, last, data} with push/pop, count, flush and valid/ready output.

## Test plan
Bench uses FIFO_SIZE=8. All cases with macro off unless stated.
1. Counts 8/8, m_ready=1 → 16 words: ch0 addr 0..7 then ch1 addr 0..7; m_last only on word 16; first m_valid at T+3; readout_done 1 cycle after the last pop.
2. Counts 8/8, READOUT_INTERLEAVE_EN defined → m_chan sequence 0,1,0,1,… over 16 words; data matches the memory models.
3. Counts 3/0 → exactly 3 words, all m_chan=0, m_last on the 3rd. Counts 0/0 → DONE at T+1 with no m_valid.
4. Random m_ready (≈50%) with counts 8/5 → no word lost or duplicated, payload stable while stalled, mem_en never leaves more than 2 words outstanding.
5. rd_abort after 4 words → m_valid low the next cycle, state IDLE. A fresh rd_start restarts from addr 0.
6. rd_start with finish_op=0, or during READ → event pulse 1 cycle later, state unchanged. finish_op falling in DONE → IDLE.
